// File: rtl/util_dac_dma_unpack.sv
// Unpacks DMA beats of two W-bit samples into one or two DAC channels.
// One beat is buffered; samples go out one cycle after each request.
module util_dac_dma_unpack #(
    parameter int CHANNEL_DATA_WIDTH = 64,
    parameter int UNDERFLOW_FILL     = 0
) (
    input  logic                            dac_clk,
    input  logic                            dac_resetn,
    input  logic                            dac_enable_0,
    input  logic                            dac_enable_1,
    input  logic                            dac_valid_0,
    input  logic                            dac_valid_1,
    output logic [CHANNEL_DATA_WIDTH-1:0]   dac_ddata_0,
    output logic [CHANNEL_DATA_WIDTH-1:0]   dac_ddata_1,
    output logic                            dac_dunf,
    input  logic                            dma_valid,
    output logic                            dma_ready,
    input  logic [2*CHANNEL_DATA_WIDTH-1:0] dma_data
);

    localparam int W = CHANNEL_DATA_WIDTH;

    logic [1:0]     mask;
    logic [1:0]     mask_q;
    logic           mask_change;
    logic           active;
    logic           dual;
    logic           req;
    logic           serve;
    logic           consume;
    logic           underflow;
    logic           accept;
    logic [2*W-1:0] buf_data;
    logic           buf_valid;
    logic           phase;
    logic [W-1:0]   lo_half;
    logic [W-1:0]   hi_half;
    logic [W-1:0]   sel_half;

    assign mask        = {dac_enable_1, dac_enable_0};
    assign mask_change = (mask != mask_q);
    assign active      = (mask != 2'b00);
    assign dual        = (mask == 2'b11);
    assign req         = dac_valid_0 | dac_valid_1;

    // A request during an enable change is never served from the stale beat.
    assign serve     = req & active & ~mask_change & buf_valid;
    assign consume   = serve & (dual | phase);
    assign underflow = req & active & (mask_change | ~buf_valid);

    assign dma_ready = active & ~mask_change & (~buf_valid | consume);
    assign accept    = dma_valid & dma_ready;

    assign lo_half  = buf_data[W-1:0];
    assign hi_half  = buf_data[2*W-1:W];
    assign sel_half = phase ? hi_half : lo_half;

    always_ff @(posedge dac_clk or negedge dac_resetn) begin
        if (!dac_resetn) begin
            mask_q      <= 2'b00;
            buf_data    <= '0;
            buf_valid   <= 1'b0;
            phase       <= 1'b0;
            dac_ddata_0 <= '0;
            dac_ddata_1 <= '0;
            dac_dunf    <= 1'b0;
        end else begin
            mask_q   <= mask;
            dac_dunf <= underflow;

            if (mask_change) begin
                buf_valid <= 1'b0;
                phase     <= 1'b0;
            end else begin
                if (accept) begin
                    buf_data  <= dma_data;
                    buf_valid <= 1'b1;
                end else if (consume) begin
                    buf_valid <= 1'b0;
                end
                if (serve && !dual) begin
                    phase <= ~phase;
                end
            end

            if (!active) begin
                dac_ddata_0 <= '0;
                dac_ddata_1 <= '0;
            end else if (serve) begin
                if (dual) begin
                    dac_ddata_0 <= lo_half;
                    dac_ddata_1 <= hi_half;
                end else begin
                    dac_ddata_0 <= mask[0] ? sel_half : '0;
                    dac_ddata_1 <= mask[1] ? sel_half : '0;
                end
            end else if (underflow && UNDERFLOW_FILL == 0) begin
                dac_ddata_0 <= '0;
                dac_ddata_1 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_util_dac_dma_unpack.sv
// Table-driven bench for util_dac_dma_unpack with both underflow policies.
// Each row is one cycle; expected outputs are queued and checked a cycle later.
module tb_util_dac_dma_unpack;

    localparam int W = 64;

    typedef struct {
        logic         en1;
        logic         en0;
        logic [1:0]   v;
        logic         dv;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         rdy;
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic         af;
        logic [W-1:0] b0;
        logic [W-1:0] b1;
    } vec_t;

    typedef struct {
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic         af;
        logic [W-1:0] b0;
        logic [W-1:0] b1;
    } exp_t;

    localparam logic [W-1:0] Z = 64'h0;
    localparam logic [W-1:0] A = 64'h1111_1111_1111_1111;
    localparam logic [W-1:0] B = 64'h2222_2222_2222_2222;
    localparam logic [W-1:0] C = 64'h3333_3333_3333_3333;
    localparam logic [W-1:0] D = 64'h4444_4444_4444_4444;
    localparam logic [W-1:0] E = 64'h5555_5555_5555_5555;
    localparam logic [W-1:0] F = 64'h6666_6666_6666_6666;
    localparam logic [W-1:0] G = 64'h7777_7777_7777_7777;
    localparam logic [W-1:0] H = 64'h8888_8888_8888_8888;
    localparam logic [W-1:0] I = 64'h9999_9999_9999_9999;
    localparam logic [W-1:0] J = 64'haaaa_aaaa_aaaa_aaaa;
    localparam logic [W-1:0] K = 64'hbbbb_bbbb_bbbb_bbbb;
    localparam logic [W-1:0] L = 64'hcccc_cccc_cccc_cccc;
    localparam logic [W-1:0] M = 64'hdddd_dddd_dddd_dddd;
    localparam logic [W-1:0] N = 64'heeee_eeee_eeee_eeee;
    localparam logic [W-1:0] O = 64'hffff_ffff_ffff_ffff;
    localparam logic [W-1:0] P = 64'h5a5a_a5a5_0f0f_f0f0;
    localparam logic [W-1:0] Q = 64'hdead_beef_0000_0001;
    localparam logic [W-1:0] R = 64'hcafe_f00d_0000_0002;
    localparam logic [W-1:0] S = 64'h0123_4567_89ab_cdef;
    localparam logic [W-1:0] T = 64'hfedc_ba98_7654_3210;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en0 = 1'b0;
    logic         en1 = 1'b0;
    logic         v0 = 1'b0;
    logic         v1 = 1'b0;
    logic         dvalid = 1'b0;
    logic [2*W-1:0] ddata = '0;

    logic [W-1:0] z_d0, z_d1, r_d0, r_d1;
    logic         z_unf, r_unf, z_rdy, r_rdy;

    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    util_dac_dma_unpack #(.CHANNEL_DATA_WIDTH(W), .UNDERFLOW_FILL(0)) dut_zero (
        .dac_clk(clk), .dac_resetn(rst_n),
        .dac_enable_0(en0), .dac_enable_1(en1),
        .dac_valid_0(v0), .dac_valid_1(v1),
        .dac_ddata_0(z_d0), .dac_ddata_1(z_d1), .dac_dunf(z_unf),
        .dma_valid(dvalid), .dma_ready(z_rdy), .dma_data(ddata)
    );

    util_dac_dma_unpack #(.CHANNEL_DATA_WIDTH(W), .UNDERFLOW_FILL(1)) dut_rep (
        .dac_clk(clk), .dac_resetn(rst_n),
        .dac_enable_0(en0), .dac_enable_1(en1),
        .dac_valid_0(v0), .dac_valid_1(v1),
        .dac_ddata_0(r_d0), .dac_ddata_1(r_d1), .dac_dunf(r_unf),
        .dma_valid(dvalid), .dma_ready(r_rdy), .dma_data(ddata)
    );

    function automatic vec_t mk(
        input logic e1, input logic e0, input logic [1:0] v, input logic dv,
        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic rdy,
        input logic [W-1:0] a0, input logic [W-1:0] a1, input logic af,
        input logic [W-1:0] b0, input logic [W-1:0] b1);
        vec_t r;
        r.en1 = e1; r.en0 = e0; r.v = v; r.dv = dv;
        r.hi = hi; r.lo = lo; r.rdy = rdy;
        r.a0 = a0; r.a1 = a1; r.af = af; r.b0 = b0; r.b1 = b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input int row);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty row %0d: got 0 entries expected 1", row);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("zero_out row %0d", row), {z_d1, z_d0, z_unf}, {e.a1, e.a0, e.af});
        chk($sformatf("rep_out row %0d", row), {r_d1, r_d0, r_unf}, {e.b1, e.b0, e.af});
    endtask

    task automatic check_idle(input string name, input logic rdy);
        chk({name, " zero"}, {z_d1, z_d0, z_unf}, '0);
        chk({name, " rep"}, {r_d1, r_d0, r_unf}, '0);
        chk({name, " ready"}, {127'b0, z_rdy, r_rdy}, {127'b0, rdy, rdy});
    endtask

    initial begin
        exp_t e;

        // both channels: plain beat, underflow x3, back-to-back accept
        vecs.push_back(mk(1,1,2'b00,1,B,A,0, Z,Z,0, Z,Z));
        vecs.push_back(mk(1,1,2'b00,1,B,A,1, Z,Z,0, Z,Z));
        vecs.push_back(mk(1,1,2'b01,0,Z,Z,1, A,B,0, A,B));
        vecs.push_back(mk(1,1,2'b00,0,Z,Z,1, A,B,0, A,B));
        vecs.push_back(mk(1,1,2'b10,0,Z,Z,1, Z,Z,1, A,B));
        vecs.push_back(mk(1,1,2'b11,0,Z,Z,1, Z,Z,1, A,B));
        vecs.push_back(mk(1,1,2'b01,0,Z,Z,1, Z,Z,1, A,B));
        vecs.push_back(mk(1,1,2'b00,0,Z,Z,1, Z,Z,0, A,B));
        vecs.push_back(mk(1,1,2'b00,1,D,C,1, Z,Z,0, A,B));
        vecs.push_back(mk(1,1,2'b01,1,F,E,1, C,D,0, C,D));
        vecs.push_back(mk(1,1,2'b01,0,Z,Z,1, E,F,0, E,F));
        vecs.push_back(mk(1,1,2'b00,0,Z,Z,1, E,F,0, E,F));
        // ch1 only: low half then high half
        vecs.push_back(mk(1,0,2'b00,0,Z,Z,0, E,F,0, E,F));
        vecs.push_back(mk(1,0,2'b00,1,H,G,1, E,F,0, E,F));
        vecs.push_back(mk(1,0,2'b10,0,Z,Z,0, Z,G,0, Z,G));
        vecs.push_back(mk(1,0,2'b10,1,J,I,1, Z,H,0, Z,H));
        vecs.push_back(mk(1,0,2'b00,0,Z,Z,0, Z,H,0, Z,H));
        vecs.push_back(mk(1,0,2'b10,0,Z,Z,0, Z,I,0, Z,I));
        // enable ch0 at phase 1: beat discarded, next starts low
        vecs.push_back(mk(1,1,2'b00,1,L,K,0, Z,I,0, Z,I));
        vecs.push_back(mk(1,1,2'b00,1,L,K,1, Z,I,0, Z,I));
        vecs.push_back(mk(1,1,2'b01,0,Z,Z,1, K,L,0, K,L));
        // request during enable change is an underflow
        vecs.push_back(mk(0,1,2'b01,1,N,M,0, Z,Z,1, K,L));
        vecs.push_back(mk(0,1,2'b00,1,N,M,1, Z,Z,0, K,L));
        vecs.push_back(mk(0,1,2'b01,0,Z,Z,0, M,Z,0, M,Z));
        vecs.push_back(mk(0,1,2'b01,0,Z,Z,1, N,Z,0, N,Z));
        vecs.push_back(mk(0,1,2'b01,0,Z,Z,1, Z,Z,1, N,Z));
        vecs.push_back(mk(0,1,2'b00,1,P,O,1, Z,Z,0, N,Z));
        vecs.push_back(mk(0,1,2'b01,0,Z,Z,0, O,Z,0, O,Z));
        // nothing enabled: requests ignored
        vecs.push_back(mk(0,0,2'b11,1,P,O,0, Z,Z,0, Z,Z));
        vecs.push_back(mk(0,0,2'b01,1,P,O,0, Z,Z,0, Z,Z));
        // load a beat ahead of the mid-stream reset
        vecs.push_back(mk(1,1,2'b00,1,R,Q,0, Z,Z,0, Z,Z));
        vecs.push_back(mk(1,1,2'b00,1,R,Q,1, Z,Z,0, Z,Z));
        vecs.push_back(mk(1,1,2'b01,1,T,S,1, Q,R,0, Q,R));

        // reset state, with enables high so ready must still be low
        en0 = 1'b1; en1 = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_idle("reset_state", 1'b0);
        @(negedge clk);
        en0 = 1'b0; en1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            en0 = vecs[i].en0;
            en1 = vecs[i].en1;
            v0 = vecs[i].v[0];
            v1 = vecs[i].v[1];
            dvalid = vecs[i].dv;
            ddata = {vecs[i].hi, vecs[i].lo};
            #1;
            chk($sformatf("ready row %0d", i), {127'b0, z_rdy, r_rdy},
                {127'b0, vecs[i].rdy, vecs[i].rdy});
            e.a0 = vecs[i].a0; e.a1 = vecs[i].a1; e.af = vecs[i].af;
            e.b0 = vecs[i].b0; e.b1 = vecs[i].b1;
            sb.push_back(e);
            @(negedge clk);
            check_outs(i);
        end

        // mid-stream reset with a buffered beat and nonzero outputs
        v0 = 1'b0; v1 = 1'b0;
        dvalid = 1'b1;
        ddata = {B, A};
        rst_n = 1'b0;
        #1 check_idle("rst_now", 1'b0);
        repeat (2) @(negedge clk);
        #1 check_idle("rst_hold", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_idle("rel_cyc1", 1'b0);
        @(negedge clk);
        #1 check_idle("rel_cyc2", 1'b1);
        dvalid = 1'b0;
        @(negedge clk);
        #1 chk("rel_no_dunf", {127'b0, z_unf, r_unf}, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
